// File: rtl/vedic_seq_ctrl.sv
// vedic_seq_ctrl
//   Computes an N x N unsigned product using one shared external 2x2 Vedic
//   multiplier cell. The cell sees one 2-bit digit pair per cycle. Its result
//   is shifted into place and added into a 2N-bit accumulator.
//
//   Optional build macro: VEDIC_ZERO_SKIP_EN
//     When defined, a zero operand skips RUN and goes straight to DONE with a
//     zero product.
//
// Ports
//   clk, rst             clock (rising edge), async active-high reset
//   in_valid / in_ready  operand handshake (in_a, in_b: N-bit unsigned)
//   out_valid / out_ready result handshake (product: 2N-bit unsigned)
//   busy                 high whenever the controller is not idle
//   core_a, core_b       digit pair driven to the shared 2x2 cell
//   core_q               4-bit combinational result from the cell
module vedic_seq_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   product,
  output logic             busy,
  output logic [1:0]       core_a,
  output logic [1:0]       core_b,
  input  logic [3:0]       core_q
);

  localparam int unsigned HALF   = N / 2;
  localparam int unsigned STEPS  = HALF * HALF;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [N-1:0]       a_reg;
  logic [N-1:0]       b_reg;
  logic [2*N-1:0]     acc;
  logic [STEP_W-1:0]  step;

  int unsigned        di;
  int unsigned        dj;
  logic [N-1:0]       a_sh;
  logic [N-1:0]       b_sh;
  logic [2*N-1:0]     q_ext;
  logic [2*N-1:0]     term;
  logic               last_step;
  logic               zero_op;

`ifdef VEDIC_ZERO_SKIP_EN
  assign zero_op = (in_a == '0) || (in_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Digit selection: i (A digit) advances fastest, j (B digit) every HALF steps.
  always_comb begin
    di        = 32'(step) % HALF;
    dj        = 32'(step) / HALF;
    a_sh      = a_reg >> (2 * di);
    b_sh      = b_reg >> (2 * dj);
    core_a    = '0;
    core_b    = '0;
    if (state == RUN) begin
      core_a = a_sh[1:0];
      core_b = b_sh[1:0];
    end
    q_ext      = '0;
    q_ext[3:0] = core_q;
    term       = q_ext << (2 * (di + dj));
    last_step  = (32'(step) == STEPS - 1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = zero_op ? DONE : RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  // Only a finished accumulation is ever visible on product.
  assign product   = out_valid ? acc : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      step  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            acc   <= '0;
            step  <= '0;
          end
        end
        RUN: begin
          acc  <= acc + term;
          step <= step + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_seq_ctrl.sv
// tb_vedic_seq_ctrl
//   Directed bench for vedic_seq_ctrl (N=8). Provides a behavioural 2x2
//   multiplier cell, a scoreboard of expected products, and checks for
//   handshake timing, digit ordering, backpressure and reset abort.
module tb_vedic_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [1:0]  core_a;
  logic [1:0]  core_b;
  logic [3:0]  core_q;

  int          nchecks;
  int          nerr;
  logic [15:0] sb[$];
  logic [7:0]  op_a;
  logic [7:0]  op_b;

  vedic_seq_ctrl #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_q    (core_q)
  );

  // External 2x2 cell model.
  assign core_q = {2'b00, core_a} * {2'b00, core_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish (observed running, expected done)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef VEDIC_ZERO_SKIP_EN
    return (a == 8'd0 || b == 8'd0) ? 0 : 16;
`else
    return 16;
`endif
  endfunction

  // Present operands, wait for acceptance, push the expected product.
  task automatic start(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("accept_ready", in_ready, 1);
    sb.push_back({8'd0, a} * {8'd0, b});
    tick();
    in_valid = 1'b0;
    in_a = ~a;
    in_b = ~b;
  endtask

  // Walk through RUN checking digit order, then the latency to out_valid.
  task automatic run_to_done();
    int lat;
    logic [7:0] ea;
    logic [7:0] eb;
    lat = 0;
    while (!out_valid && lat < 100) begin
      ea = (op_a >> (2 * (lat % 4))) & 8'd3;
      eb = (op_b >> (2 * (lat / 4))) & 8'd3;
      chk("run_in_ready", in_ready, 0);
      chk("run_busy", busy, 1);
      chk("run_core_a", core_a, ea);
      chk("run_core_b", core_b, eb);
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat(op_a, op_b));
    chk("done_core_a", core_a, 0);
    chk("done_core_b", core_b, 0);
    chk("done_in_ready", in_ready, 0);
  endtask

  // Hold backpressure for 'hold' cycles, then complete the handshake.
  task automatic finish(input int hold);
    logic [15:0] exp;
    out_ready = 1'b0;
    exp = (sb.size() != 0) ? sb[0] : 16'hxxxx;
    chk("sb_nonempty", (sb.size() != 0), 1);
    repeat (hold) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_product", product, exp);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    chk("hs_valid", out_valid, 1);
    if (sb.size() != 0) exp = sb.pop_front();
    chk("product", product, exp);
    tick();
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    nchecks = 0;
    nerr = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (2) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_core_b", core_b, 0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1);

    start(8'd13, 8'd11);
    run_to_done();
    finish(0);

    start(8'hFF, 8'hFF);
    run_to_done();
    finish(0);

    start(8'hA5, 8'h3C);
    run_to_done();
    finish(10);

    // Next operands are already valid during DONE; they must wait for IDLE.
    start(8'd200, 8'd3);
    run_to_done();
    in_a = 8'd7;
    in_b = 8'd9;
    in_valid = 1'b1;
    finish(0);
    start(8'd7, 8'd9);
    run_to_done();
    finish(0);

    // Asynchronous reset in the middle of RUN step 7.
    start(8'hFF, 8'h02);
    repeat (7) tick();
    chk("abort_busy_before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_product", product, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_acc", dut.acc, 0);
    chk("abort_core_a", core_a, 0);
    void'(sb.pop_back());
    tick();
    rst = 1'b0;
    tick();
    chk("abort_release_ready", in_ready, 1);

    start(8'd5, 8'd5);
    run_to_done();
    finish(0);

    start(8'd0, 8'd77);
    run_to_done();
    finish(0);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
